// File: rtl/apb_slave_regfile.sv
// APB completer with a bank of DEPTH 32-bit read/write registers, programmable
// wait states, and an error response for misaligned or out-of-range accesses.
module apb_slave_regfile #(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        pclk_s,
   input  logic        prst_s,
   input  logic        psel_s,
   input  logic        penable_s,
   input  logic        pwrite_s,
   input  logic [31:0] paddress_s,
   input  logic [31:0] pwdata_s,
   output logic [31:0] prdata_s,
   output logic        pready_s,
   output logic        pslverr_s
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READY} state_e;

   state_e           state_q;
   logic [31:0]      mem_q [DEPTH];
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] idx_d;
   logic             write_q;
   logic             err_q;
   logic             err_d;
   logic [31:0]      wdata_q;
   logic [3:0]       cnt_q;
   logic [31:0]      prdata_q;
   logic             pready_q;
   logic             pslverr_q;

   // Live decode of the setup-phase address; latched into idx_q/err_q in IDLE.
   always_comb begin
      idx_d = paddress_s[2 +: IDX_W];
      err_d = (paddress_s[1:0] != 2'b00) || (paddress_s >= 32'(4 * DEPTH));
   end

   // NOTE: all state uses non-blocking assignments so every register samples
   // the values from before the edge, regardless of statement order.
   always_ff @(posedge pclk_s or posedge prst_s) begin
      if (prst_s) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         write_q   <= 1'b0;
         err_q     <= 1'b0;
         wdata_q   <= '0;
         cnt_q     <= '0;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         // NOTE: the register bank is reset because software relies on reading
         // 0 after reset; this keeps it in flops rather than a RAM macro.
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (psel_s && !penable_s) begin
                  idx_q   <= idx_d;
                  write_q <= pwrite_s;
                  wdata_q <= pwdata_s;
                  err_q   <= err_d;
                  cnt_q   <= 4'(WAIT_CYCLES);
                  if (WAIT_CYCLES == 0) begin
                     state_q   <= ST_READY;
                     pready_q  <= 1'b1;
                     pslverr_q <= err_d;
                     prdata_q  <= (pwrite_s || err_d) ? '0 : mem_q[idx_d];
                  end else begin
                     state_q <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (!psel_s) begin
                  state_q <= ST_IDLE;
               end else if (penable_s) begin
                  if (cnt_q == 4'd1) begin
                     state_q   <= ST_READY;
                     pready_q  <= 1'b1;
                     pslverr_q <= err_q;
                     prdata_q  <= (write_q || err_q) ? '0 : mem_q[idx_q];
                  end else begin
                     cnt_q <= cnt_q - 4'd1;
                  end
               end
            end
            ST_READY: begin
               // A deselect on the completion edge abandons the write.
               if (psel_s && write_q && !err_q) begin
                  mem_q[idx_q] <= wdata_q;
               end
               state_q   <= ST_IDLE;
               pready_q  <= 1'b0;
               pslverr_q <= 1'b0;
               prdata_q  <= '0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign prdata_s  = prdata_q;
   assign pready_s  = pready_q;
   assign pslverr_s = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: three instances on one bus with
// WAIT_CYCLES of 0, 3 and 2, selected individually through psel.
module tb_apb_slave_regfile;

   logic        clk;
   logic        rst;
   logic [2:0]  psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata [3];
   logic [2:0]  pready;
   logic [2:0]  pslverr;

   int n_cmp = 0;
   int n_err = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      apb_slave_regfile #(
         .DEPTH      (16),
         .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 3 : 2))
      ) u_dut (
         .pclk_s    (clk),
         .prst_s    (rst),
         .psel_s    (psel[g]),
         .penable_s (penable),
         .pwrite_s  (pwrite),
         .paddress_s(paddr),
         .pwdata_s  (pwdata),
         .prdata_s  (prdata[g]),
         .pready_s  (pready[g]),
         .pslverr_s (pslverr[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int wc(input int d);
      return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One complete transfer on device d, checking pready on every access cycle.
   task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input bit exp_err,
                       input logic [31:0] exp_rd, input bit mutate, input bit rst_mid);
      @(posedge clk); #1;
      psel    = '0;
      psel[d] = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = a;
      pwdata  = wd;
      chk($sformatf("d%0d %h setup pready", d, a), 32'(pready[d]), 32'd0);
      @(posedge clk); #1;
      penable = 1'b1;
      if (mutate) pwdata = 32'h0;
      for (int k = 0; k <= wc(d); k++) begin
         chk($sformatf("d%0d %h pready c%0d", d, a, k), 32'(pready[d]),
             (k == wc(d)) ? 32'd1 : 32'd0);
         if (k < wc(d)) begin
            @(posedge clk); #1;
         end
      end
      chk($sformatf("d%0d %h pslverr", d, a), 32'(pslverr[d]), 32'(exp_err));
      chk($sformatf("d%0d %h prdata", d, a), prdata[d], exp_rd);
      if (rst_mid) begin
         #3 rst = 1'b1;
         #1;
         chk($sformatf("d%0d %h rst pready", d, a), 32'(pready[d]), 32'd0);
         chk($sformatf("d%0d %h rst pslverr", d, a), 32'(pslverr[d]), 32'd0);
         @(posedge clk); #1;
         rst     = 1'b0;
         psel    = '0;
         penable = 1'b0;
      end
   endtask

   task automatic bus_idle();
      @(posedge clk); #1;
      psel    = '0;
      penable = 1'b0;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("d%0d idle pready", d), 32'(pready[d]), 32'd0);
      end
   endtask

   initial begin
      rst     = 1'b1;
      psel    = '0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      #2;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("d%0d reset prdata", d), prdata[d], 32'h0);
         chk($sformatf("d%0d reset pready", d), 32'(pready[d]), 32'd0);
         chk($sformatf("d%0d reset pslverr", d), 32'(pslverr[d]), 32'd0);
      end
      #10 rst = 1'b0;

      // Fresh registers all read 0, back to back.
      for (int i = 0; i < 16; i++) begin
         xfer(0, 1'b0, 32'(i * 4), 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      end

      // Write then immediate read-back; neighbours untouched.
      xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0);
      xfer(0, 1'b0, 32'h08, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
      xfer(0, 1'b0, 32'h04, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      xfer(0, 1'b0, 32'h0C, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

      // Error accesses leave the bank unchanged and read back 0.
      xfer(0, 1'b1, 32'h40, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0, 1'b0);
      xfer(0, 1'b1, 32'h06, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0, 1'b0);
      xfer(0, 1'b0, 32'h40, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
      xfer(0, 1'b0, 32'h00, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      xfer(0, 1'b0, 32'h04, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      xfer(0, 1'b0, 32'h08, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
      bus_idle();

      // Three wait states; pwdata cleared during the access phase is ignored.
      xfer(1, 1'b1, 32'h3C, 32'h12345678, 1'b0, 32'h0, 1'b1, 1'b0);
      xfer(1, 1'b0, 32'h3C, 32'h0, 1'b0, 32'h12345678, 1'b0, 1'b0);
      bus_idle();

      // Abort: deselect at S+2 of a two-wait write.
      xfer(2, 1'b1, 32'h10, 32'h11112222, 1'b0, 32'h0, 1'b0, 1'b0);
      @(posedge clk); #1;
      psel    = 3'b100;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 32'h10;
      pwdata  = 32'hA5A5A5A5;
      @(posedge clk); #1;
      penable = 1'b1;
      chk("abort pready S+1", 32'(pready[2]), 32'd0);
      @(posedge clk); #1;
      psel    = '0;
      penable = 1'b0;
      chk("abort pready S+2", 32'(pready[2]), 32'd0);
      @(posedge clk); #1;
      chk("abort pready S+3", 32'(pready[2]), 32'd0);
      @(posedge clk); #1;
      chk("abort pready S+4", 32'(pready[2]), 32'd0);
      xfer(2, 1'b0, 32'h10, 32'h0, 1'b0, 32'h11112222, 1'b0, 1'b0);

      // Asynchronous reset mid-cycle while pready (and pslverr) are high.
      xfer(2, 1'b1, 32'h14, 32'h0BADF00D, 1'b0, 32'h0, 1'b0, 1'b1);
      xfer(2, 1'b0, 32'h14, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      xfer(2, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      xfer(2, 1'b1, 32'h40, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0, 1'b1);
      xfer(0, 1'b0, 32'h08, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      xfer(1, 1'b0, 32'h3C, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      bus_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
